// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM encoding, IR field layout and control-unit opcode constants
package mem_access_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h01;
  localparam logic [5:0] OP_SW = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h03;
  localparam logic [5:0] OP_SUBI = 6'h04;
  localparam logic [5:0] OP_BEQ = 6'h05;
  localparam logic [5:0] OP_J = 6'h06;
  localparam logic [5:0] FUNCT_FIRST = 6'h32;
  localparam logic [5:0] FUNCT_LAST = 6'h37;
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_unit_ir_field_split.sv
// ir_field_split: combinational decode of an instruction word into its fields
module ir_field_split
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);
  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs = ir[RS_HI:RS_LO];
  assign rt = ir[RT_HI:RT_LO];
  assign rd = ir[RD_HI:RD_LO];
  assign funct = ir[FUNCT_HI:FUNCT_LO];
  assign imm16 = ir[IMM_HI:IMM_LO];
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: address select, req/ack bus transaction with timeout, IR/MDR load
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              bus_err
);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic dst_ir_q, dst_ir_d;
  logic req_d, we_d, err_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DATA_W-1:0] wdata_d, ir_d, mdr_d;
  assign addr = ior_d ? alu_out : pc;
  assign busy = state_q != IDLE;
  // next-state and next-register values; a request is accepted only from IDLE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dst_ir_d = dst_ir_q;
    req_d = bus_req;
    we_d = bus_we;
    addr_d = bus_addr;
    wdata_d = bus_wdata;
    ir_d = ir;
    mdr_d = mdr;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (mem_read | mem_write) begin
        err_d = ~word_aligned(addr[1:0]) | (mem_read & mem_write);
        if (word_aligned(addr[1:0])) begin
          state_d = REQ;
          req_d = 1'b1;
          we_d = mem_write;
          addr_d = addr;
          wdata_d = store_data;
          dst_ir_d = ir_write & ~mem_write;
          cnt_d = 8'd0;
        end
      end
      REQ: if (bus_ack) begin
        state_d = DONE;
        req_d = 1'b0;
        ir_d = (!bus_we && dst_ir_q) ? bus_rdata : ir;
        mdr_d = (!bus_we && !dst_ir_q) ? bus_rdata : mdr;
      end else if (cnt_q == 8'(TIMEOUT)) begin
        state_d = IDLE;
        req_d = 1'b0;
        err_d = 1'b1;
      end else cnt_d = cnt_q + 8'd1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // register all state and bus outputs; reset abandons any transaction
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      dst_ir_q <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      ir <= '0;
      mdr <= '0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dst_ir_q <= dst_ir_d;
      bus_req <= req_d;
      bus_we <= we_d;
      bus_addr <= addr_d;
      bus_wdata <= wdata_d;
      ir <= ir_d;
      mdr <= mdr_d;
      bus_err <= err_d;
    end
  end
  ir_field_split u_split (
    .ir(ir[31:0]),
    .opcode(opcode),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .funct(funct),
    .imm16(imm16)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench driving a variable-latency bus responder
module tb_mem_access_unit;
  localparam int TIMEOUT = 15;
  logic clock = 1'b0;
  logic reset, mem_read, mem_write, ior_d, ir_write, bus_ack;
  logic [31:0] pc, alu_out, store_data, bus_rdata;
  logic bus_req, bus_we, busy, bus_err;
  logic [31:0] bus_addr, bus_wdata, ir, mdr;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  int checks = 0;
  int failures = 0;
  logic [31:0] ir_m = '0;
  logic [31:0] mdr_m = '0;
  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} req_t;
  req_t exp_q[$];

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .ior_d(ior_d), .ir_write(ir_write), .pc(pc), .alu_out(alu_out),
    .store_data(store_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .ir(ir), .opcode(opcode), .funct(funct), .rs(rs),
    .rt(rt), .rd(rd), .imm16(imm16), .mdr(mdr), .busy(busy), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic rd_i, input logic wr_i, input logic iord, input logic irw,
                    input logic [31:0] p, input logic [31:0] a, input logic [31:0] sd,
                    input int waits, input logic [31:0] rdata);
    logic [31:0] addr;
    logic aligned;
    logic stable;
    req_t e;
    int n;
    addr = iord ? a : p;
    aligned = addr[1:0] == 2'b00;
    mem_read = rd_i;
    mem_write = wr_i;
    ior_d = iord;
    ir_write = irw;
    pc = p;
    alu_out = a;
    store_data = sd;
    if (aligned) exp_q.push_back('{addr, wr_i, sd});
    @(negedge clock);
    mem_read = 1'b0;
    mem_write = 1'b0;
    chk("err_issue", bus_err, !aligned || (rd_i && wr_i));
    if (!aligned) begin
      chk("no_req", bus_req, 0);
      chk("idle_busy", busy, 0);
      @(negedge clock);
      chk("err_pulse", bus_err, 0);
      chk("no_req_later", bus_req, 0);
      return;
    end
    chk("sb_nonempty", exp_q.size(), 1);
    e = exp_q.pop_front();
    chk("req", bus_req, 1);
    chk("addr", bus_addr, e.addr);
    chk("we", bus_we, e.we);
    chk("wdata", bus_wdata, e.wdata);
    chk("busy", busy, 1);
    n = 0;
    stable = 1'b1;
    while (bus_req && n < 40) begin
      if (bus_addr !== e.addr || bus_we !== e.we || bus_wdata !== e.wdata) stable = 1'b0;
      bus_ack = (n == waits);
      bus_rdata = rdata;
      @(negedge clock);
      bus_ack = 1'b0;
      n++;
    end
    if (waits >= 0 && !wr_i) begin
      if (irw) ir_m = rdata;
      else mdr_m = rdata;
    end
    chk("req_cycles", n, waits < 0 ? TIMEOUT + 1 : waits + 1);
    chk("hold", stable, 1);
    chk("done_busy", busy, waits >= 0);
    chk("to_err", bus_err, waits < 0);
    chk("ir", ir, ir_m);
    chk("mdr", mdr, mdr_m);
    @(negedge clock);
    chk("back_idle", busy, 0);
    chk("err_clear", bus_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {mem_read, mem_write, ior_d, ir_write, bus_ack} = '0;
    pc = '0;
    alu_out = '0;
    store_data = '0;
    bus_rdata = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_err", bus_err, 0);
    op(1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 0, 32'h0443_0005);
    chk("opcode", opcode, 6'h01);
    chk("rs", rs, 5'd2);
    chk("rt", rt, 5'd3);
    chk("imm16", imm16, 16'h0005);
    op(1, 0, 1, 0, 32'h0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    op(0, 1, 1, 0, 32'h0, 32'h200, 32'h1234_5678, 2, 32'hFFFF_FFFF);
    op(1, 0, 1, 1, 32'h0, 32'h300, 32'h0, -1, 32'h5555_5555);
    op(1, 0, 1, 0, 32'h0, 32'h102, 32'h0, 0, 32'h0);
    op(1, 1, 1, 1, 32'h0, 32'h40, 32'hA5A5_A5A5, 0, 32'h7777_7777);
    op(1, 0, 1, 0, 32'h0, 32'h44, 32'h0, TIMEOUT, 32'hCAFE_0001);
    op(1, 0, 0, 1, 32'h8, 32'h0, 32'h0, 1, 32'h0000_0034);
    chk("funct", funct, 6'h34);
    mem_read = 1'b1;
    ir_write = 1'b1;
    ior_d = 1'b0;
    pc = 32'h20;
    @(negedge clock);
    mem_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rr_req", bus_req, 0);
    chk("rr_busy", busy, 0);
    chk("rr_ir", ir, 0);
    chk("rr_opcode", opcode, 0);
    chk("rr_mdr", mdr, 0);
    bus_ack = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    bus_ack = 1'b0;
    chk("late_ack_ir", ir, 0);
    chk("late_ack_busy", busy, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
